// File: rtl/tlp_tx_arbiter_if.sv
// TLP stream bundle: NUM_SRC generator streams in and one hard-IP TX stream out.
// The arbiter uses the slave modport and the generators/hard-IP side uses the master modport.
interface tlp_tx_arbiter_if #(
   parameter int NUM_SRC = 2
);
   // Valid/ready: a beat moves in a cycle where valid and ready are both high.
   // Ready never depends on valid; a source may derive valid from its ready.
   // srcReq_in must never depend on srcReady_out.
   logic [NUM_SRC-1:0]    srcReq_in;
   logic [NUM_SRC*64-1:0] srcData_in;
   logic [NUM_SRC-1:0]    srcValid_in;
   logic [NUM_SRC-1:0]    srcSOP_in;
   logic [NUM_SRC-1:0]    srcEOP_in;
   logic [NUM_SRC-1:0]    srcReady_out;
   logic [63:0]           txData_out;
   logic                  txValid_out;
   logic                  txReady_in;
   logic                  txSOP_out;
   logic                  txEOP_out;

   modport slave (
      input  srcReq_in, srcData_in, srcValid_in, srcSOP_in, srcEOP_in, txReady_in,
      output srcReady_out, txData_out, txValid_out, txSOP_out, txEOP_out
   );

   modport master (
      output srcReq_in, srcData_in, srcValid_in, srcSOP_in, srcEOP_in, txReady_in,
      input  srcReady_out, txData_out, txValid_out, txSOP_out, txEOP_out
   );
endinterface

// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one 64-bit SOP/EOP TX stream among NUM_SRC TLP
// generators. The ready and data paths are purely combinational; only grant state is registered.
module tlp_tx_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int ERR_W   = 16
) (
   input  logic             pcieClk_in,
   input  logic             pcieRst_in,
   tlp_tx_arbiter_if.slave  txBus,
   output logic [ERR_W-1:0] errCount_out,
   output logic             errSticky_out,
   output logic             stateDbg_out
);
   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t           state, stateNext;
   logic [IDX_W-1:0] gnt, gntNext;
   logic [IDX_W-1:0] lastGnt, lastGntNext;
   logic [IDX_W-1:0] rrSel, sel, candIdx;
   int               rrCand;
   logic             anyReq, grantOn, accepted, beatSop, beatEop, violation;
   logic [63:0]      selData;

   // Walk candidates from farthest to nearest so the first requester after lastGnt wins.
   always_comb begin
      rrSel   = lastGnt;
      rrCand  = 0;
      candIdx = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         rrCand = int'(lastGnt) + k;
         if (rrCand >= NUM_SRC) rrCand = rrCand - NUM_SRC;
         candIdx = IDX_W'(rrCand);
         if (txBus.srcReq_in[candIdx]) rrSel = candIdx;
      end
   end

   assign sel     = (state == S_LOCKED) ? gnt : rrSel;
   assign anyReq  = |txBus.srcReq_in;
   // Reset forces every ready low at once, which also kills the forwarded valid.
   assign grantOn = !pcieRst_in && txBus.txReady_in &&
                    (((state == S_IDLE) && anyReq) || (state == S_LOCKED));

   always_comb begin
      txBus.srcReady_out      = '0;
      txBus.srcReady_out[sel] = grantOn;
   end

   always_comb begin
      selData = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == IDX_W'(i)) selData = txBus.srcData_in[64*i +: 64];
      end
   end

   assign txBus.txValid_out = txBus.srcValid_in[sel] & txBus.srcReady_out[sel];
   assign txBus.txSOP_out   = txBus.txValid_out & txBus.srcSOP_in[sel];
   assign txBus.txEOP_out   = txBus.txValid_out & txBus.srcEOP_in[sel];
   assign txBus.txData_out  = txBus.txValid_out ? selData : 64'd0;

   assign accepted = txBus.txValid_out & txBus.txReady_in;
   assign beatSop  = txBus.srcSOP_in[sel];
   assign beatEop  = txBus.srcEOP_in[sel];

   assign violation = (|(txBus.srcValid_in & ~txBus.srcReady_out)) ||
                      (accepted && (state == S_IDLE) && !beatSop) ||
                      (accepted && (state == S_LOCKED) && beatSop);

   // The round-robin pointer only moves on EOP, so a request that never starts keeps its turn.
   always_comb begin
      stateNext   = state;
      gntNext     = gnt;
      lastGntNext = lastGnt;
      case (state)
         S_IDLE: begin
            if (accepted && beatSop) begin
               if (beatEop) begin
                  lastGntNext = sel;
               end else begin
                  stateNext = S_LOCKED;
                  gntNext   = sel;
               end
            end
         end
         S_LOCKED: begin
            if (accepted && beatEop) begin
               stateNext   = S_IDLE;
               lastGntNext = gnt;
            end
         end
         default: stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
      if (pcieRst_in) begin
         state   <= S_IDLE;
         gnt     <= '0;
         lastGnt <= IDX_W'(NUM_SRC - 1);
      end else begin
         state   <= stateNext;
         gnt     <= gntNext;
         lastGnt <= lastGntNext;
      end
   end

   always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
      if (pcieRst_in) begin
         errCount_out  <= '0;
         errSticky_out <= 1'b0;
      end else if (violation) begin
         errSticky_out <= 1'b1;
         if (errCount_out != {ERR_W{1'b1}}) errCount_out <= errCount_out + ERR_W'(1);
      end
   end

   assign stateDbg_out = (state == S_LOCKED);
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Scoreboard bench for tlp_tx_arbiter: per-source packet queues feed the DUT, a packet-level
// round-robin model predicts the TX beat order, and a monitor compares every accepted beat.
module tb_tlp_tx_arbiter;
   localparam int NUM_SRC = 3;
   localparam int ERR_W   = 16;
   localparam int W       = 66;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [63:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [ERR_W-1:0] errCount;
   logic             errSticky;
   logic             stateDbg;

   always #5 clk = ~clk;

   tlp_tx_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

   tlp_tx_arbiter #(.NUM_SRC(NUM_SRC), .ERR_W(ERR_W)) dut (
      .pcieClk_in   (clk),
      .pcieRst_in   (rst),
      .txBus        (bus),
      .errCount_out (errCount),
      .errSticky_out(errSticky),
      .stateDbg_out (stateDbg)
   );

   logic [W-1:0]       exp_q[$];
   beat_t              srcQ[NUM_SRC][$];
   beat_t              mdlQ[NUM_SRC][$];
   int                 mdlLen[NUM_SRC][$];
   int                 batchCnt[NUM_SRC];
   int                 batchLen[NUM_SRC];
   logic [NUM_SRC-1:0] srcHave;
   logic [NUM_SRC-1:0] injValid;
   logic [NUM_SRC-1:0] accMask;
   int                 readyMode;
   int                 modelPtr;
   int                 expErr;
   int                 total = 0;
   int                 bad   = 0;
   int                 cycle = 0;
   int                 accCount, firstAcc, lastAcc, firstSrc;
   bit                 lock0Seen;

   // Sources only raise valid when offered ready, except for deliberate injections.
   assign bus.srcValid_in = (srcHave & bus.srcReady_out) | injValid;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic int pending();
      int n;
      n = 0;
      for (int i = 0; i < NUM_SRC; i++) n += srcQ[i].size();
      return n;
   endfunction

   task automatic flush_all();
      for (int i = 0; i < NUM_SRC; i++) begin
         srcQ[i].delete();
         mdlQ[i].delete();
         mdlLen[i].delete();
      end
      exp_q.delete();
   endtask

   // Build packets, hand them to the sources, and predict the beat order at packet level.
   task automatic load_batch();
      int left;
      int s;
      int len;
      beat_t bt;
      left = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int p = 0; p < batchCnt[i]; p++) begin
            len = (batchLen[i] > 0) ? batchLen[i] : int'($urandom_range(1, 5));
            mdlLen[i].push_back(len);
            for (int b = 0; b < len; b++) begin
               bt.sop  = (b == 0);
               bt.eop  = (b == len - 1);
               bt.data = {$urandom(), $urandom()};
               srcQ[i].push_back(bt);
               mdlQ[i].push_back(bt);
            end
            left++;
         end
      end
      while (left > 0) begin
         s = -1;
         for (int k = 1; k <= NUM_SRC; k++) begin
            if (s < 0 && mdlLen[(modelPtr + k) % NUM_SRC].size() > 0) s = (modelPtr + k) % NUM_SRC;
         end
         len = mdlLen[s].pop_front();
         for (int b = 0; b < len; b++) exp_q.push_back(mdlQ[s].pop_front());
         modelPtr = s;
         left--;
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || pending() > 0) && n < 2000) begin
         @(posedge clk);
         n++;
      end
      total++;
      if (n >= 2000) begin
         bad++;
         $display("FAIL %s drain: beats left=%0d expected 0", name, exp_q.size());
         flush_all();
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_acc(input int k, input string name);
      int n;
      n = 0;
      while (accCount < k && n < 200) begin
         @(posedge clk);
         n++;
      end
      total++;
      if (accCount < k) begin
         bad++;
         $display("FAIL %s: accepted=%0d expected>=%0d", name, accCount, k);
      end
   endtask

   initial begin : driver
      bus.srcReq_in  = '0;
      bus.srcData_in = '0;
      bus.srcSOP_in  = '0;
      bus.srcEOP_in  = '0;
      bus.txReady_in = 1'b0;
      srcHave        = '0;
      accMask        = '0;
      forever begin
         @(negedge clk);
         accMask = bus.srcValid_in & bus.srcReady_out & {NUM_SRC{bus.txReady_in}} & ~injValid;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (accMask[i] && srcQ[i].size() > 0) srcQ[i].delete(0);
            srcHave[i]       = (srcQ[i].size() > 0);
            bus.srcReq_in[i] = srcHave[i];
            if (srcHave[i]) begin
               bus.srcData_in[64*i +: 64] = srcQ[i][0].data;
               bus.srcSOP_in[i]           = srcQ[i][0].sop;
               bus.srcEOP_in[i]           = srcQ[i][0].eop;
            end else begin
               bus.srcData_in[64*i +: 64] = 64'd0;
               bus.srcSOP_in[i]           = 1'b0;
               bus.srcEOP_in[i]           = 1'b0;
            end
         end
         case (readyMode)
            0:       bus.txReady_in = 1'b1;
            1:       bus.txReady_in = ($urandom_range(0, 3) != 0);
            default: bus.txReady_in = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      logic [W-1:0] got;
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         cycle++;
         if (!rst) begin
            check("ready_onehot", W'($countones(bus.srcReady_out) <= 1), W'(1));
            if (!bus.txReady_in) check("stall_quiet", W'({bus.txValid_out, bus.srcReady_out}), '0);
            if (!bus.txValid_out) check("framing_idle", W'({bus.txSOP_out, bus.txEOP_out}), '0);
            if (stateDbg && bus.srcReady_out[0]) lock0Seen = 1'b1;
            if (bus.txValid_out && bus.txReady_in) begin
               got = {bus.txSOP_out, bus.txEOP_out, bus.txData_out};
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL tx_beat: got=%h expected none at t=%0t", got, $time);
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp) begin
                     bad++;
                     $display("FAIL tx_beat: got=%h expected=%h at t=%0t", got, exp, $time);
                  end
               end
               accCount++;
               if (accCount == 1) begin
                  firstAcc = cycle;
                  for (int i = 0; i < NUM_SRC; i++) if (bus.srcReady_out[i]) firstSrc = i;
               end
               lastAcc = cycle;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : main
      readyMode = 0;
      injValid  = '0;
      modelPtr  = NUM_SRC - 1;
      expErr    = 0;
      accCount  = 0;
      firstSrc  = -1;
      lock0Seen = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_ready", W'(bus.srcReady_out), '0);
      check("rst_tx", W'({bus.txValid_out, bus.txSOP_out, bus.txEOP_out}), '0);
      check("rst_err", W'({errCount, errSticky}), '0);
      check("rst_state", W'(stateDbg), '0);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back 4-beat packets alternate with no gap between EOP and next SOP.
      batchCnt = '{3, 3, 0};
      batchLen = '{4, 4, 0};
      accCount = 0;
      load_batch();
      wait_drain("alternate");
      check("no_gap", W'(lastAcc - firstAcc + 1), W'(24));
      check("alt_err", W'(errCount), W'(expErr));

      // Downstream stall mid-packet keeps the lock and offers no ready.
      batchCnt = '{1, 1, 0};
      batchLen = '{6, 4, 0};
      accCount = 0;
      load_batch();
      wait_acc(2, "stall_setup");
      readyMode = 2;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_hold", W'({bus.txValid_out, bus.srcReady_out, stateDbg}), W'(1));
      end
      readyMode = 0;
      wait_drain("stall");

      // Single-beat packets from src0 never take the lock.
      batchCnt  = '{2, 2, 0};
      batchLen  = '{1, 3, 0};
      lock0Seen = 1'b0;
      load_batch();
      wait_drain("single_beat");
      check("single_nolock", W'(lock0Seen), '0);

      // Only src2 requesting, then src0 and src2: the pointer wraps to src0.
      batchCnt = '{0, 0, 5};
      batchLen = '{0, 0, 0};
      load_batch();
      wait_drain("src2_only");
      batchCnt = '{1, 0, 1};
      accCount = 0;
      firstSrc = -1;
      load_batch();
      wait_drain("wrap");
      check("wrap_first", W'(firstSrc), W'(0));

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            batchCnt[i] = $urandom_range(0, 3);
            batchLen[i] = 0;
         end
         if (batchCnt[0] + batchCnt[1] + batchCnt[2] == 0) batchCnt[$urandom_range(0, 2)] = 1;
         readyMode = $urandom_range(0, 1);
         load_batch();
         wait_drain("random");
         check("random_err", W'({errCount, errSticky}), W'({ERR_W'(expErr), 1'b0}));
      end
      readyMode = 0;

      // Valid from a non-owner while src0 is locked is counted and not forwarded.
      batchCnt = '{1, 0, 0};
      batchLen = '{4, 0, 0};
      load_batch();
      begin
         int n;
         n = 0;
         while (n < 50) begin
            @(posedge clk);
            #2;
            n++;
            if (stateDbg) break;
         end
      end
      check("lock_taken", W'(stateDbg), W'(1));
      injValid = 3'b010;
      expErr   = 1;
      @(posedge clk);
      #2;
      injValid = '0;
      wait_drain("violation");
      check("viol_count", W'(errCount), W'(expErr));
      check("viol_sticky", W'(errSticky), W'(1));

      // Reset in the middle of a packet drops everything immediately.
      batchCnt = '{1, 1, 0};
      batchLen = '{4, 4, 0};
      accCount = 0;
      load_batch();
      wait_acc(2, "reset_setup");
      #2;
      rst = 1'b1;
      #1;
      check("midrst_ready", W'(bus.srcReady_out), '0);
      check("midrst_tx", W'({bus.txValid_out, bus.txSOP_out, bus.txEOP_out}), '0);
      check("midrst_err", W'({errCount, errSticky, stateDbg}), '0);
      flush_all();
      modelPtr = NUM_SRC - 1;
      expErr   = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_err", W'(errCount), '0);
      batchCnt = '{2, 2, 0};
      batchLen = '{0, 0, 0};
      accCount = 0;
      firstSrc = -1;
      load_batch();
      wait_drain("post_reset");
      check("post_rst_first", W'(firstSrc), W'(0));
      check("post_rst_err_end", W'({errCount, errSticky}), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
